hbridge_supervisor: RTL and testbench
=====================================

Name: hbridge_supervisor

Overview:
- Parametrised H-bridge start-up, gating and protection sequencer for N half-bridge legs.
- Replaces the ad-hoc ON/VG/ALERT/ENABLE_RST glue at the top level with one registered FSM.
- Sequence: idle, then bootstrap charge (low sides on), then forced initial state, then run (pass-through of the hybrid-control MOSFET pattern after dead-time insertion).
- Latches shoot-through and external faults until explicitly cleared.

Parameters:
- N_LEG, 2, number of half-bridge legs; switch vector width is 2*N_LEG.
- CNT_W, 8, width of the phase timer.
- T_BOOT, 10, cycles spent in BOOT (10 us at 1 MHz).
- T_FORCE, 6, cycles spent in FORCE.
- FORCE_PATTERN, 4'b1001, switch pattern applied in FORCE; width 2*N_LEG.

Ports:
- i_CLK  input  1  system clock
- i_RST  input  1  asynchronous reset, active-low
- i_enable  input  1  converter enable, already debounced
- i_clear  input  1  fault clear request, level
- i_ext_fault  input  1  external fault (over-current/over-voltage), active-high
- i_Q  input  2*N_LEG  requested switch pattern. Bit k is the high side of leg k; bit k+N_LEG is the low side of leg k.
- o_Q  output  2*N_LEG  gated switch pattern to the gate drivers
- o_state  output  3  IDLE=0, BOOT=1, FORCE=2, RUN=3, FAULT=4
- o_on  output  1  high in FORCE and RUN (bootstrap done)
- o_vg  output  1  high in RUN only
- o_ctrl_rst_n  output  1  active-low reset for the downstream controller/PI; low in every state except RUN
- o_fault  output  1  high in FAULT
- o_fault_cause  output  2  bit0 = shoot-through, bit1 = external; captured on entry to FAULT

Behaviour:
- Clock/reset: one clock, i_CLK. i_RST asynchronous active-low.
- All outputs are registered. On reset:
  - o_Q=0, o_state=IDLE, o_on=0, o_vg=0, o_ctrl_rst_n=0, o_fault=0, o_fault_cause=0.
  - Timer cleared.
- Shoot-through detect (st): combinational OR over legs of (i_Q[k] & i_Q[k+N_LEG]).
- Next-state priority each cycle, highest first:
  1. Fault entry.
  2. Enable drop.
  3. Phase timing.
- IDLE:
  - o_Q=0.
  - i_enable=1 -> BOOT, timer=0.
  - i_ext_fault is ignored in IDLE.
- BOOT:
  - o_Q = low sides all on ({N_LEG{1}},{N_LEG{0}}); timer increments each cycle.
  - When timer==T_BOOT-1 -> FORCE, timer=0. BOOT therefore lasts exactly T_BOOT cycles.
- FORCE:
  - o_Q = FORCE_PATTERN.
  - When timer==T_FORCE-1 -> RUN. FORCE lasts exactly T_FORCE cycles.
- RUN:
  - o_Q = i_Q registered, giving 1-cycle latency from i_Q to o_Q.
  - o_ctrl_rst_n=1.
- Fault entry:
  - Condition: i_ext_fault=1 in BOOT/FORCE/RUN, or st=1 in RUN.
  - Next state is FAULT. o_Q=0 on the same edge, so an offending pattern never reaches o_Q.
  - o_fault_cause records which conditions were true on that cycle; both bits may be set.
  - Fault takes priority over i_enable=0 on the same cycle.
- Enable drop: i_enable=0 in BOOT/FORCE/RUN -> IDLE, o_Q=0 on the next edge, timer cleared.
- FAULT:
  - o_Q=0 and o_fault=1; o_fault_cause is held.
  - Exits to IDLE only when i_enable=0 and i_clear=1 on the same cycle; o_fault_cause is then cleared.
  - i_clear while i_enable=1 has no effect.
- st outside RUN is ignored; the BOOT and FORCE patterns are generated internally.
- The timer saturates and never wraps. Require T_BOOT, T_FORCE in 1..2^CNT_W-1.
- FORCE_PATTERN must not contain shoot-through; the bench asserts this at elaboration.
- Asynchronous reset mid-sequence returns to IDLE with all switches off immediately, without waiting for a clock edge.
- o_on/o_vg/o_ctrl_rst_n are decoded from the next state and registered with o_state, so they change on the same edge as o_state.

Test Plan:
- Nominal start (N_LEG=2, T_BOOT=10, T_FORCE=6, i_Q=4'b0110): raise i_enable at cycle 0.
  - o_state: BOOT from edge 1 for 10 cycles, with o_Q=4'b1100.
  - Then FORCE for 6 cycles, with o_Q=4'b1001 and o_on=1.
  - Then RUN, with o_vg=1, o_ctrl_rst_n=1 and o_Q=4'b0110.
  - A change of i_Q to 4'b1001 appears on o_Q one cycle later.
- Enable drop mid-BOOT at timer=5: next edge o_state=IDLE, o_Q=0. Re-enable: BOOT restarts and lasts the full 10 cycles.
- Shoot-through in RUN, i_Q=4'b0101 (leg0 high and low both on):
  - Next edge: o_state=FAULT, o_Q=0, o_fault_cause=2'b01; 4'b0101 never appears on o_Q.
  - i_clear=1 with i_enable=1 -> stays in FAULT.
  - Then i_enable=0, i_clear=1 -> IDLE, cause cleared.
- i_ext_fault pulse of 1 cycle during FORCE, with i_enable dropped on the same cycle: FAULT wins, o_fault_cause=2'b10, and the fault stays latched after i_ext_fault returns to 0.
- Asynchronous reset asserted in RUN between clock edges: o_Q=0 and o_state=IDLE before the next edge. After release with i_enable=1, the full BOOT/FORCE sequence repeats.
- Generalisation, N_LEG=3, FORCE_PATTERN=6'b100011, T_BOOT=1:
  - BOOT lasts 1 cycle with o_Q=6'b111000.
  - Shoot-through on leg2 (bits 2 and 5) is detected in RUN.

Source files
------------

// File: rtl/hbridge_supervisor.sv
// H-bridge start-up, gating and protection sequencer for N_LEG half-bridge legs.
// IDLE -> BOOT (low sides on) -> FORCE (fixed pattern) -> RUN (pass-through), with latched faults.
module hbridge_supervisor #(
   parameter int unsigned           N_LEG         = 2,
   parameter int unsigned           CNT_W         = 8,
   parameter int unsigned           T_BOOT        = 10,
   parameter int unsigned           T_FORCE       = 6,
   parameter logic [2*N_LEG-1:0]    FORCE_PATTERN = 4'b1001
) (
   input  logic                 i_CLK,
   input  logic                 i_RST,
   input  logic                 i_enable,
   input  logic                 i_clear,
   input  logic                 i_ext_fault,
   input  logic [2*N_LEG-1:0]   i_Q,
   output logic [2*N_LEG-1:0]   o_Q,
   output logic [2:0]           o_state,
   output logic                 o_on,
   output logic                 o_vg,
   output logic                 o_ctrl_rst_n,
   output logic                 o_fault,
   output logic [1:0]           o_fault_cause
);

   localparam int unsigned W = 2 * N_LEG;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_BOOT  = 3'd1;
   localparam logic [2:0] S_FORCE = 3'd2;
   localparam logic [2:0] S_RUN   = 3'd3;
   localparam logic [2:0] S_FAULT = 3'd4;

   localparam logic [CNT_W-1:0] BOOT_LAST  = CNT_W'(T_BOOT - 1);
   localparam logic [CNT_W-1:0] FORCE_LAST = CNT_W'(T_FORCE - 1);

   logic [2:0]       r_state;
   logic [CNT_W-1:0] r_timer;
   logic [W-1:0]     r_Q;
   logic             r_on;
   logic             r_vg;
   logic             r_ctrl_rst_n;
   logic             r_fault;
   logic [1:0]       r_fault_cause;

   logic             w_st;
   logic             w_active;
   logic             w_fault_req;
   logic [2:0]       w_nxt_state;
   logic [CNT_W-1:0] w_nxt_timer;
   logic [CNT_W-1:0] w_timer_inc;
   logic [1:0]       w_nxt_cause;
   logic [W-1:0]     w_nxt_Q;

   assign w_st        = |(i_Q[N_LEG-1:0] & i_Q[W-1:N_LEG]);
   assign w_active    = (r_state == S_BOOT) || (r_state == S_FORCE) || (r_state == S_RUN);
   assign w_fault_req = (w_active && i_ext_fault) || ((r_state == S_RUN) && w_st);
   // Saturating increment: the timer must never wrap back into a terminal-count match.
   assign w_timer_inc = (r_timer == '1) ? r_timer : r_timer + 1'b1;

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_timer = r_timer;
      w_nxt_cause = r_fault_cause;
      case (r_state)
         S_IDLE: begin
            if (i_enable) begin
               w_nxt_state = S_BOOT;
               w_nxt_timer = '0;
            end
         end
         S_BOOT, S_FORCE, S_RUN: begin
            if (w_fault_req) begin
               w_nxt_state = S_FAULT;
               w_nxt_timer = '0;
               w_nxt_cause = {i_ext_fault, w_st && (r_state == S_RUN)};
            end else if (!i_enable) begin
               w_nxt_state = S_IDLE;
               w_nxt_timer = '0;
            end else if (r_state == S_BOOT) begin
               if (r_timer == BOOT_LAST) begin
                  w_nxt_state = S_FORCE;
                  w_nxt_timer = '0;
               end else begin
                  w_nxt_timer = w_timer_inc;
               end
            end else if (r_state == S_FORCE) begin
               if (r_timer == FORCE_LAST) begin
                  w_nxt_state = S_RUN;
                  w_nxt_timer = '0;
               end else begin
                  w_nxt_timer = w_timer_inc;
               end
            end
         end
         S_FAULT: begin
            if (!i_enable && i_clear) begin
               w_nxt_state = S_IDLE;
               w_nxt_cause = '0;
            end
         end
         default: begin
            w_nxt_state = S_IDLE;
            w_nxt_timer = '0;
            w_nxt_cause = '0;
         end
      endcase
   end

   // Gate pattern is decoded from the next state so a faulting pattern is blocked on the same edge.
   always_comb begin
      w_nxt_Q = '0;
      case (w_nxt_state)
         S_BOOT:  w_nxt_Q = {{N_LEG{1'b1}}, {N_LEG{1'b0}}};
         S_FORCE: w_nxt_Q = FORCE_PATTERN;
         S_RUN:   w_nxt_Q = i_Q;
         default: w_nxt_Q = '0;
      endcase
   end

   always_ff @(posedge i_CLK or negedge i_RST) begin
      if (!i_RST) begin
         r_state       <= S_IDLE;
         r_timer       <= '0;
         r_Q           <= '0;
         r_on          <= 1'b0;
         r_vg          <= 1'b0;
         r_ctrl_rst_n  <= 1'b0;
         r_fault       <= 1'b0;
         r_fault_cause <= '0;
      end else begin
         r_state       <= w_nxt_state;
         r_timer       <= w_nxt_timer;
         r_Q           <= w_nxt_Q;
         r_on          <= (w_nxt_state == S_FORCE) || (w_nxt_state == S_RUN);
         r_vg          <= (w_nxt_state == S_RUN);
         r_ctrl_rst_n  <= (w_nxt_state == S_RUN);
         r_fault       <= (w_nxt_state == S_FAULT);
         r_fault_cause <= w_nxt_cause;
      end
   end

   assign o_Q           = r_Q;
   assign o_state       = r_state;
   assign o_on          = r_on;
   assign o_vg          = r_vg;
   assign o_ctrl_rst_n  = r_ctrl_rst_n;
   assign o_fault       = r_fault;
   assign o_fault_cause = r_fault_cause;

endmodule

// File: tb/tb_hbridge_supervisor.sv
// Bench for hbridge_supervisor: two instances (2 legs default, 3 legs short boot) checked
// every cycle against a phase/elapsed-cycle reference model, directed steps then random traffic.
module tb_hbridge_supervisor;

   localparam logic [3:0] FPA = 4'b1001;
   localparam logic [5:0] FPB = 6'b100011;

   typedef struct {
      int         ph;      // 0 idle, 1 boot, 2 force, 3 run, 4 fault
      int         t;       // cycles already spent in the current phase
      logic [5:0] q;
      logic [1:0] cause;
   } mdl_t;

   logic       clk = 1'b0;
   logic       rstA, rstB;
   logic       enA, clrA, extA, enB, clrB, extB;
   logic [3:0] qA, oQA;
   logic [5:0] qB, oQB;
   logic [2:0] stA, stB;
   logic       onA, vgA, crA, fA, onB, vgB, crB, fB;
   logic [1:0] fcA, fcB;

   int   n_assert = 0;
   int   n_fail   = 0;
   mdl_t mA, mB;

   always #5 clk = ~clk;

   hbridge_supervisor #(.N_LEG(2), .CNT_W(8), .T_BOOT(10), .T_FORCE(6), .FORCE_PATTERN(FPA)) u_a (
      .i_CLK(clk), .i_RST(rstA), .i_enable(enA), .i_clear(clrA), .i_ext_fault(extA), .i_Q(qA),
      .o_Q(oQA), .o_state(stA), .o_on(onA), .o_vg(vgA), .o_ctrl_rst_n(crA), .o_fault(fA),
      .o_fault_cause(fcA));

   hbridge_supervisor #(.N_LEG(3), .CNT_W(8), .T_BOOT(1), .T_FORCE(6), .FORCE_PATTERN(FPB)) u_b (
      .i_CLK(clk), .i_RST(rstB), .i_enable(enB), .i_clear(clrB), .i_ext_fault(extB), .i_Q(qB),
      .o_Q(oQB), .o_state(stB), .o_on(onB), .o_vg(vgB), .o_ctrl_rst_n(crB), .o_fault(fB),
      .o_fault_cause(fcB));

   function automatic mdl_t idle_m();
      mdl_t m;
      m.ph = 0; m.t = 0; m.q = '0; m.cause = '0;
      return m;
   endfunction

   function automatic mdl_t mnext(mdl_t m, logic en, logic clr, logic ext, logic [5:0] q,
                                  int nleg, int tb, int tf, logic [5:0] fp);
      mdl_t n;
      int   mask;
      int   hi, lo;
      bit   st;
      mask = (1 << nleg) - 1;
      hi   = int'(q) & mask;
      lo   = (int'(q) >> nleg) & mask;
      st   = (hi & lo) != 0;
      n    = m;
      if (m.ph == 0) begin
         if (en) begin n.ph = 1; n.t = 1; end
      end else if (m.ph == 4) begin
         if (!en && clr) begin n.ph = 0; n.cause = 2'b00; end
      end else if (ext || (m.ph == 3 && st)) begin
         n.ph = 4;
         n.cause = {ext, (m.ph == 3) && st};
      end else if (!en) begin
         n.ph = 0;
      end else if (m.ph == 1) begin
         if (m.t == tb) begin n.ph = 2; n.t = 1; end else n.t = m.t + 1;
      end else if (m.ph == 2) begin
         if (m.t == tf) begin n.ph = 3; n.t = 1; end else n.t = m.t + 1;
      end
      case (n.ph)
         1:       n.q = 6'(mask << nleg);
         2:       n.q = fp;
         3:       n.q = q;
         default: n.q = '0;
      endcase
      return n;
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [7:0] flags(int ph, logic [1:0] cause);
      logic on, vg;
      on = (ph == 2) || (ph == 3);
      vg = (ph == 3);
      return {2'b00, on, vg, vg, (ph == 4), cause};
   endfunction

   task automatic check_all();
      chk("A_state", {5'b0, stA}, 8'(mA.ph));
      chk("A_q",     {4'b0, oQA}, {4'b0, mA.q[3:0]});
      chk("A_flags", {2'b00, onA, vgA, crA, fA, fcA}, flags(mA.ph, mA.cause));
      chk("B_state", {5'b0, stB}, 8'(mB.ph));
      chk("B_q",     {2'b0, oQB}, {2'b0, mB.q});
      chk("B_flags", {2'b00, onB, vgB, crB, fB, fcB}, flags(mB.ph, mB.cause));
   endtask

   task automatic tick();
      mdl_t na, nb;
      na = rstA ? mnext(mA, enA, clrA, extA, {2'b00, qA}, 2, 10, 6, {2'b00, FPA}) : idle_m();
      nb = rstB ? mnext(mB, enB, clrB, extB, qB, 3, 1, 6, FPB) : idle_m();
      @(posedge clk);
      #1;
      mA = na;
      mB = nb;
      check_all();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      if ((FPA[1:0] & FPA[3:2]) != 2'b00 || (FPB[2:0] & FPB[5:3]) != 3'b000)
         $fatal(1, "FAIL force_pattern contains shoot-through");
      rstA = 1'b0; rstB = 1'b0;
      enA = 1'b0; clrA = 1'b0; extA = 1'b0; qA = 4'b0110;
      enB = 1'b0; clrB = 1'b0; extB = 1'b0; qB = 6'b001010;
      mA = idle_m(); mB = idle_m();
      #1;
      check_all();
      tick();
      rstA = 1'b1;

      // nominal start-up on the 2-leg instance
      enA = 1'b1;
      ticks(17);
      chk("A_run_q", {4'b0, oQA}, 8'h06);
      ticks(1);
      qA = 4'b1001;
      ticks(2);

      // enable drop mid-BOOT, then a full restart
      enA = 1'b0; ticks(1);
      enA = 1'b1; ticks(6);
      enA = 1'b0; ticks(1);
      chk("A_drop_state", {5'b0, stA}, 8'd0);
      enA = 1'b1; qA = 4'b0110; ticks(17);

      // shoot-through in RUN, clear ignored while enabled
      qA = 4'b0101; ticks(1);
      chk("A_st_cause", {6'b0, fcA}, 8'h01);
      clrA = 1'b1; qA = 4'b0110; ticks(2);
      enA = 1'b0; ticks(1);
      clrA = 1'b0;

      // external fault in FORCE coincident with enable drop
      enA = 1'b1; ticks(12);
      extA = 1'b1; enA = 1'b0; ticks(1);
      chk("A_ext_cause", {6'b0, fcA}, 8'h02);
      extA = 1'b0; ticks(3);
      clrA = 1'b1; ticks(1);
      clrA = 1'b0;

      // asynchronous reset between edges while in RUN
      enA = 1'b1; ticks(19);
      #2 rstA = 1'b0;
      #1;
      chk("A_async_state", {5'b0, stA}, 8'd0);
      chk("A_async_q", {4'b0, oQA}, 8'h00);
      #1 rstA = 1'b1;
      mA = idle_m();
      ticks(19);

      // 3-leg instance: one-cycle boot, leg2 shoot-through
      rstB = 1'b1; enB = 1'b1;
      ticks(1);
      chk("B_boot_q", {2'b0, oQB}, 8'h38);
      ticks(8);
      qB = 6'b100100; ticks(1);
      chk("B_st_cause", {6'b0, fcB}, 8'h01);
      enB = 1'b0; clrB = 1'b1; ticks(1);
      clrB = 1'b0;

      // randomized traffic on both instances
      for (int i = 0; i < 600; i++) begin
         enA  = ($urandom % 10) != 0;
         clrA = ($urandom % 4) == 0;
         extA = ($urandom % 40) == 0;
         qA   = 4'($urandom);
         if (($urandom % 4) != 0) qA[1:0] = qA[1:0] & ~qA[3:2];
         enB  = ($urandom % 10) != 0;
         clrB = ($urandom % 4) == 0;
         extB = ($urandom % 40) == 0;
         qB   = 6'($urandom);
         if (($urandom % 4) != 0) qB[2:0] = qB[2:0] & ~qB[5:3];
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
